// File: rtl/prco_mem_responder_pkg.sv
// Shared constants for the prco memory responder: FSM encodings, MMIO offsets,
// region codes and the address decoder.
package prco_mem_responder_pkg;

    localparam logic [3:0] ST_IDLE   = 4'b0001;
    localparam logic [3:0] ST_WAIT   = 4'b0010;
    localparam logic [3:0] ST_ACCESS = 4'b0100;
    localparam logic [3:0] ST_RESP   = 4'b1000;

    localparam logic [7:0] MMIO_DBG  = 8'h00;
    localparam logic [7:0] MMIO_CYC  = 8'h01;
    localparam logic [7:0] MMIO_SCR  = 8'h02;
    localparam logic [7:0] MMIO_STAT = 8'h03;

    typedef enum logic [1:0] {
        REGION_RAM      = 2'd0,
        REGION_MMIO     = 2'd1,
        REGION_UNMAPPED = 2'd2
    } region_t;

    // RAM takes priority if a low MMIO_BASE ever overlaps the RAM range.
    function automatic region_t decode_region(input logic [15:0] addr,
                                              input int          addr_w,
                                              input logic [15:0] mmio_base);
        logic [16:0] ram_top;
        ram_top = 17'd1 << addr_w;
        if ({1'b0, addr} < ram_top)
            return REGION_RAM;
        else if (addr >= mmio_base)
            return REGION_MMIO;
        else
            return REGION_UNMAPPED;
    endfunction

endpackage

// File: rtl/prco_mem_responder_spram.sv
// Single-port synchronous RAM, 16-bit words, registered read, no reset so it
// maps onto block RAM.
module prco_spram #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              ce,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [15:0]       din,
    output logic [15:0]       dout
);

    logic [15:0] mem [0:(2**ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (ce) begin
            if (we)
                mem[addr] <= din;
            else
                dout <= mem[addr];
        end
    end

endmodule

// File: rtl/prco_mem_responder.sv
// Memory-side responder: req/ack single-word accesses to internal RAM or a small
// MMIO window, with programmable wait states and unmapped-address errors.
module prco_mem_responder
    import prco_mem_responder_pkg::*;
#(
    parameter int          ADDR_W      = 10,
    parameter int          WAIT_STATES = 0,
    parameter logic [15:0] MMIO_BASE   = 16'hFF00
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [15:0] i_addr,
    input  logic [15:0] i_wdata,
    output logic        q_ack,
    output logic [15:0] q_rdata,
    output logic        q_err,
    output logic        q_busy,
    output logic [7:0]  q_debug
);

    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    logic [3:0]  state_reg, state_next;
    logic        we_reg;
    logic [15:0] addr_reg;
    logic [15:0] wdata_reg;
    region_t     region_reg;
    logic [3:0]  wait_cnt_reg;
    logic [15:0] cyc_reg;
    logic [15:0] scratch_reg;
    logic [7:0]  dbg_reg;
    logic [15:0] mmio_rdata_reg;
    logic [15:0] mmio_rdata;
    logic [15:0] mmio_off;
    logic [15:0] ram_dout;
    logic        ram_ce;
    logic        in_access;

    assign in_access = (state_reg == ST_ACCESS);
    assign ram_ce    = in_access && (region_reg == REGION_RAM);
    assign mmio_off  = addr_reg - MMIO_BASE;

    prco_spram #(.ADDR_W(ADDR_W)) u_ram (
        .clk  (i_clk),
        .ce   (ram_ce),
        .we   (we_reg),
        .addr (addr_reg[ADDR_W-1:0]),
        .din  (wdata_reg),
        .dout (ram_dout)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (i_req) state_next = (WAIT_STATES > 0) ? ST_WAIT : ST_ACCESS;
            ST_WAIT:   if (wait_cnt_reg == 4'd0) state_next = ST_ACCESS;
            ST_ACCESS: state_next = ST_RESP;
            ST_RESP:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        mmio_rdata = 16'h0000;
        case (mmio_off)
            {8'h00, MMIO_DBG}:  mmio_rdata = {8'h00, dbg_reg};
            {8'h00, MMIO_CYC}:  mmio_rdata = cyc_reg;
            {8'h00, MMIO_SCR}:  mmio_rdata = scratch_reg;
            {8'h00, MMIO_STAT}: mmio_rdata = {12'h000, 4'(WAIT_STATES)};
            default:            mmio_rdata = 16'h0000;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_reg      <= ST_IDLE;
            we_reg         <= 1'b0;
            addr_reg       <= 16'h0000;
            wdata_reg      <= 16'h0000;
            region_reg     <= REGION_UNMAPPED;
            wait_cnt_reg   <= 4'd0;
            cyc_reg        <= 16'h0000;
            scratch_reg    <= 16'h0000;
            dbg_reg        <= 8'h00;
            mmio_rdata_reg <= 16'h0000;
            q_ack          <= 1'b0;
            q_err          <= 1'b0;
            q_rdata        <= 16'h0000;
        end else begin
            state_reg <= state_next;
            cyc_reg   <= cyc_reg + 16'd1;

            if (state_reg == ST_IDLE && i_req) begin
                we_reg       <= i_we;
                addr_reg     <= i_addr;
                wdata_reg    <= i_wdata;
                region_reg   <= decode_region(i_addr, ADDR_W, MMIO_BASE);
                wait_cnt_reg <= WAIT_LOAD;
            end else if (state_reg == ST_WAIT && wait_cnt_reg != 4'd0) begin
                wait_cnt_reg <= wait_cnt_reg - 4'd1;
            end

            // MMIO reads are snapshotted in ACCESS so the counter reflects that cycle.
            if (in_access && region_reg == REGION_MMIO) begin
                mmio_rdata_reg <= mmio_rdata;
                if (we_reg) begin
                    if (mmio_off == {8'h00, MMIO_DBG}) dbg_reg     <= wdata_reg[7:0];
                    if (mmio_off == {8'h00, MMIO_SCR}) scratch_reg <= wdata_reg;
                end
            end

            if (state_reg == ST_RESP) begin
                q_ack <= 1'b1;
                q_err <= (region_reg == REGION_UNMAPPED);
                if (!we_reg && region_reg == REGION_RAM)
                    q_rdata <= ram_dout;
                else if (!we_reg && region_reg == REGION_MMIO)
                    q_rdata <= mmio_rdata_reg;
                else
                    q_rdata <= 16'h0000;
            end else begin
                q_ack   <= 1'b0;
                q_err   <= 1'b0;
                q_rdata <= 16'h0000;
            end
        end
    end

    assign q_busy  = (state_reg != ST_IDLE);
    assign q_debug = dbg_reg;

endmodule

// File: tb/tb_prco_mem_responder.sv
// Self-checking bench: two responders (0 and 3 wait states) driven by directed and
// random transactions, checked against a word-level model of RAM and MMIO.
module tb_prco_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req   [2];
    logic        we    [2];
    logic [15:0] addr  [2];
    logic [15:0] wdata [2];
    logic        ack   [2];
    logic [15:0] rdata [2];
    logic        err   [2];
    logic        busy  [2];
    logic [7:0]  dbg   [2];

    int checks = 0;
    int errors = 0;
    int ws [2] = '{0, 3};

    // reference model state
    logic [15:0] mram [2][32];
    logic [7:0]  mdbg [2];
    logic [15:0] mscr [2];
    logic [15:0] m_cyc;

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n)
        if (!rst_n) m_cyc <= 16'h0000;
        else        m_cyc <= m_cyc + 16'd1;

    prco_mem_responder #(.ADDR_W(10), .WAIT_STATES(0), .MMIO_BASE(16'hFF00)) dut0 (
        .i_clk(clk), .i_reset_n(rst_n), .i_req(req[0]), .i_we(we[0]),
        .i_addr(addr[0]), .i_wdata(wdata[0]), .q_ack(ack[0]), .q_rdata(rdata[0]),
        .q_err(err[0]), .q_busy(busy[0]), .q_debug(dbg[0])
    );

    prco_mem_responder #(.ADDR_W(10), .WAIT_STATES(3), .MMIO_BASE(16'hFF00)) dut1 (
        .i_clk(clk), .i_reset_n(rst_n), .i_req(req[1]), .i_we(we[1]),
        .i_addr(addr[1]), .i_wdata(wdata[1]), .q_ack(ack[1]), .q_rdata(rdata[1]),
        .q_err(err[1]), .q_busy(busy[1]), .q_debug(dbg[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s ack d%0d", tag, d),   {31'd0, ack[d]},  32'd0);
            chk($sformatf("%s busy d%0d", tag, d),  {31'd0, busy[d]}, 32'd0);
            chk($sformatf("%s err d%0d", tag, d),   {31'd0, err[d]},  32'd0);
            chk($sformatf("%s rdata d%0d", tag, d), {16'd0, rdata[d]}, 32'd0);
            chk($sformatf("%s debug d%0d", tag, d), {24'd0, dbg[d]},  {24'd0, mdbg[d]});
        end
    endtask

    // One request/response; expectations derived from the model before updating it.
    task automatic txn(input int d, input logic w, input logic [15:0] a, input logic [15:0] wd);
        logic [15:0] cyc0;
        logic [15:0] exp_rd;
        logic        exp_err;
        int          lat;
        @(negedge clk);
        req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd;
        @(posedge clk);
        #1;
        cyc0 = m_cyc;
        req[d] = 1'b0;
        exp_rd  = 16'h0000;
        exp_err = 1'b0;
        if (a < 16'h0400) begin
            if (!w) exp_rd = mram[d][a[4:0]];
        end else if (a >= 16'hFF00) begin
            if (!w) begin
                case (a[7:0])
                    8'h00:   exp_rd = {8'h00, mdbg[d]};
                    8'h01:   exp_rd = cyc0 + 16'(ws[d]);
                    8'h02:   exp_rd = mscr[d];
                    8'h03:   exp_rd = 16'(ws[d]);
                    default: exp_rd = 16'h0000;
                endcase
            end
        end else begin
            exp_err = 1'b1;
        end
        lat = -1;
        for (int k = 0; k < 20 && lat < 0; k++) begin
            @(negedge clk);
            if (ack[d] === 1'b1) begin
                lat = k;
            end else begin
                chk($sformatf("busy d%0d a%h k%0d", d, a, k), {31'd0, busy[d]},
                    (k < 2 + ws[d]) ? 32'd1 : 32'd0);
                chk($sformatf("rdata-idle d%0d a%h", d, a), {16'd0, rdata[d]}, 32'd0);
            end
        end
        chk($sformatf("latency d%0d a%h", d, a), lat, 2 + ws[d]);
        chk($sformatf("rdata d%0d we%0d a%h", d, w, a), {16'd0, rdata[d]}, {16'd0, exp_rd});
        chk($sformatf("err d%0d a%h", d, a), {31'd0, err[d]}, {31'd0, exp_err});
        chk($sformatf("busy-at-ack d%0d", d), {31'd0, busy[d]}, 32'd0);
        if (w) begin
            if (a < 16'h0400) mram[d][a[4:0]] = wd;
            else if (a == 16'hFF00) mdbg[d] = wd[7:0];
            else if (a == 16'hFF02) mscr[d] = wd;
        end
        chk($sformatf("debug d%0d", d), {24'd0, dbg[d]}, {24'd0, mdbg[d]});
        $display("txn d%0d we=%0d addr=%h wdata=%h -> rdata=%h err=%0d lat=%0d",
                 d, w, a, wd, rdata[d], err[d], lat);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req[d] = 1'b0; we[d] = 1'b0; addr[d] = 16'h0; wdata[d] = 16'h0;
            mdbg[d] = 8'h00; mscr[d] = 16'h0000;
        end
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        rst_n = 1'b1;

        // give every modelled RAM word a known value
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 32; i++)
                txn(d, 1'b1, 16'(i), 16'($urandom));

        // directed scenarios
        txn(0, 1'b1, 16'h0005, 16'hBEEF);
        txn(0, 1'b0, 16'h0005, 16'h0000);
        txn(1, 1'b1, 16'h0005, 16'hBEEF);
        txn(1, 1'b0, 16'h0005, 16'h0000);
        txn(0, 1'b1, 16'hFF00, 16'h12A5);
        txn(0, 1'b0, 16'hFF00, 16'h0000);
        txn(0, 1'b1, 16'hFF01, 16'h0000);
        txn(0, 1'b0, 16'hFF01, 16'h0000);
        txn(1, 1'b0, 16'hFF03, 16'h0000);
        txn(0, 1'b1, 16'h0400, 16'h1111);
        txn(0, 1'b0, 16'h0000, 16'h0000);

        // back-to-back: req held high, acks every third cycle
        @(negedge clk);
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 16'h0005;
        @(posedge clk);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk($sformatf("b2b ack k%0d", k), {31'd0, ack[0]}, (k % 3 == 2) ? 32'd1 : 32'd0);
            if (k % 3 == 2)
                chk($sformatf("b2b rdata k%0d", k), {16'd0, rdata[0]}, {16'd0, mram[0][5]});
            $display("b2b k=%0d ack=%0d rdata=%h", k, ack[0], rdata[0]);
        end
        req[0] = 1'b0;
        repeat (3) @(negedge clk);
        chk("b2b drained busy", {31'd0, busy[0]}, 32'd0);

        // abort a write during its wait states
        @(negedge clk);
        req[1] = 1'b1; we[1] = 1'b1; addr[1] = 16'h0010; wdata[1] = 16'h5555;
        @(posedge clk);
        #1;
        req[1] = 1'b0;
        @(negedge clk);
        chk("abort in wait", {31'd0, busy[1]}, 32'd1);
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            mdbg[d] = 8'h00; mscr[d] = 16'h0000;
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("abort no ack k%0d", k), {31'd0, ack[1]}, 32'd0);
        end
        chk_idle_outputs("re-reset");
        rst_n = 1'b1;
        txn(1, 1'b0, 16'h0010, 16'h0000);
        txn(1, 1'b0, 16'hFF00, 16'h0000);

        // random mix across both responders
        for (int i = 0; i < 40; i++) begin
            int d;
            int r;
            logic [15:0] a;
            d = int'($urandom_range(0, 1));
            r = int'($urandom_range(0, 2));
            if (r == 0)      a = 16'($urandom_range(0, 31));
            else if (r == 1) a = 16'hFF00 + 16'($urandom_range(0, 7));
            else             a = 16'($urandom_range(16'h0400, 16'hFEFF));
            txn(d, 1'($urandom_range(0, 1)), a, 16'($urandom));
        end

        // counter wrap
        repeat (65536) @(posedge clk);
        txn(0, 1'b0, 16'hFF01, 16'h0000);
        txn(1, 1'b0, 16'hFF01, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
